// File: rtl/data_cache_emulator.sv
// data_cache_emulator: fixed-latency data memory that drains committed stores and serves LSQ loads,
// one access in flight, stores ahead of loads, loads cancellable by flush.
module data_cache_emulator #(
    parameter int ADDR_W     = 8,
    parameter int WR_LATENCY = 4,
    parameter int RD_LATENCY = 4
) (
    input  logic        Clk,
    input  logic        Resetb,
    input  logic        SB_DataValid,
    input  logic [31:0] SB_AddrDmem,
    input  logic [31:0] SB_DataDmem,
    output logic        DCE_WriteDone,
    input  logic        Lsq_ReadValid,
    input  logic [31:0] Lsq_ReadAddr,
    input  logic [5:0]  Lsq_ReadTag,
    output logic        DCE_ReadAck,
    output logic        DCE_ReadDone,
    output logic [31:0] DCE_ReadData,
    output logic [5:0]  DCE_ReadTag,
    input  logic        Cdb_Flush
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
    logic [5:0] tag;
    logic [31:0] mem [2**ADDR_W];
    logic write_accept;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{SB_AddrDmem[31:ADDR_W+2], SB_AddrDmem[1:0],
                                Lsq_ReadAddr[31:ADDR_W+2], Lsq_ReadAddr[1:0]};
    // The WriteDone gate keeps the entry being released from being taken a second time.
    assign write_accept = !Resetb && state == IDLE && SB_DataValid && !DCE_WriteDone;
    assign DCE_ReadAck = !Resetb && state == IDLE && Lsq_ReadValid && !Cdb_Flush && !write_accept;
    always_ff @(posedge Clk)
        if (!Resetb && state == WRITE && cnt == 4'd1) mem[addr] <= data;
    always_ff @(posedge Clk) begin
        if (Resetb) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            DCE_WriteDone <= 1'b0;
            DCE_ReadDone  <= 1'b0;
            DCE_ReadData  <= 32'h0;
            DCE_ReadTag   <= 6'h0;
        end else begin
            DCE_WriteDone <= 1'b0;
            DCE_ReadDone  <= 1'b0;
            case (state)
                IDLE:
                    if (write_accept) begin
                        addr  <= SB_AddrDmem[ADDR_W+1:2];
                        data  <= SB_DataDmem;
                        cnt   <= 4'(WR_LATENCY - 1);
                        state <= WRITE;
                    end else if (DCE_ReadAck) begin
                        addr  <= Lsq_ReadAddr[ADDR_W+1:2];
                        tag   <= Lsq_ReadTag;
                        cnt   <= 4'(RD_LATENCY - 1);
                        state <= READ;
                    end
                WRITE:
                    if (cnt == 4'd1) begin
                        DCE_WriteDone <= 1'b1;
                        state         <= IDLE;
                    end else cnt <= cnt - 4'd1;
                READ:
                    if (Cdb_Flush) state <= IDLE;
                    else if (cnt == 4'd1) begin
                        DCE_ReadData <= mem[addr];
                        DCE_ReadTag  <= tag;
                        DCE_ReadDone <= 1'b1;
                        state        <= IDLE;
                    end else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache_emulator.sv
// tb_data_cache_emulator: directed and random traffic scored against a transaction-level memory model.
module tb_data_cache_emulator;
    localparam int WL = 4;
    localparam int RL = 4;
    logic        Clk = 1'b0;
    logic        Resetb = 1'b0;
    logic        SB_DataValid = 1'b0;
    logic [31:0] SB_AddrDmem = 32'h0;
    logic [31:0] SB_DataDmem = 32'h0;
    logic        DCE_WriteDone;
    logic        Lsq_ReadValid = 1'b0;
    logic [31:0] Lsq_ReadAddr = 32'h0;
    logic [5:0]  Lsq_ReadTag = 6'h0;
    logic        DCE_ReadAck;
    logic        DCE_ReadDone;
    logic [31:0] DCE_ReadData;
    logic [5:0]  DCE_ReadTag;
    logic        Cdb_Flush = 1'b0;

    always #5 Clk = ~Clk;

    data_cache_emulator #(.ADDR_W(8), .WR_LATENCY(WL), .RD_LATENCY(RL)) dut (
        .Clk(Clk), .Resetb(Resetb),
        .SB_DataValid(SB_DataValid), .SB_AddrDmem(SB_AddrDmem), .SB_DataDmem(SB_DataDmem),
        .DCE_WriteDone(DCE_WriteDone),
        .Lsq_ReadValid(Lsq_ReadValid), .Lsq_ReadAddr(Lsq_ReadAddr), .Lsq_ReadTag(Lsq_ReadTag),
        .DCE_ReadAck(DCE_ReadAck), .DCE_ReadDone(DCE_ReadDone),
        .DCE_ReadData(DCE_ReadData), .DCE_ReadTag(DCE_ReadTag),
        .Cdb_Flush(Cdb_Flush)
    );

    typedef struct {int cyc; bit rd; logic [31:0] data; logic [5:0] tag;} ev_t;
    typedef struct {logic [31:0] a; logic [31:0] d;} st_t;
    ev_t exq[$];
    st_t sbq[$];
    int wd_cycles[$];
    logic [31:0] mem [0:255];
    int cyc = 0, checks = 0, failures = 0;
    int busy_end = 0, wdone_cyc = -1, rd_acc = -1, pend_commit = -1;
    bit mon_en = 0, pend_v = 0, lsq_v = 0, clear_sb = 0, dut_ack = 0;
    logic [7:0]  pend_i;
    logic [31:0] pend_d, lsq_a, last_rd_data = 32'h0;
    logic [5:0]  lsq_t, last_rd_tag = 6'h0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", n, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides what the memory must do this cycle.
    task automatic step(input bit rst, input bit flush);
        int t;
        bit idle, wacc, racc;
        @(negedge Clk);
        t = cyc;
        Resetb = rst;
        Cdb_Flush = flush;
        SB_DataValid = sbq.size() > 0;
        if (sbq.size() > 0) begin
            SB_AddrDmem = sbq[0].a;
            SB_DataDmem = sbq[0].d;
        end
        Lsq_ReadValid = lsq_v;
        Lsq_ReadAddr = lsq_a;
        Lsq_ReadTag = lsq_t;
        #1;
        racc = 0;
        if (rst) begin
            while (exq.size() > 0 && exq[exq.size()-1].cyc > t) exq.delete(exq.size()-1);
            pend_v = 0;
            busy_end = t + 1;
            rd_acc = -1;
            if (wdone_cyc > t) wdone_cyc = -1;
        end else begin
            if (rd_acc >= 0 && flush && t > rd_acc && t < rd_acc + RL) begin
                exq.delete(exq.size()-1);
                busy_end = t + 1;
                rd_acc = -1;
            end
            idle = t >= busy_end;
            wacc = idle && sbq.size() > 0 && t != wdone_cyc;
            racc = idle && lsq_v && !flush && !wacc;
            if (wacc) begin
                exq.push_back('{t + WL, 1'b0, 32'h0, 6'h0});
                busy_end = t + WL;
                wdone_cyc = t + WL;
                pend_v = 1;
                pend_i = sbq[0].a[9:2];
                pend_d = sbq[0].d;
                pend_commit = t + WL - 1;
            end
            if (racc) begin
                exq.push_back('{t + RL, 1'b1, mem[lsq_a[9:2]], lsq_t});
                busy_end = t + RL;
                rd_acc = t;
            end
            if (pend_v && t == pend_commit) begin
                mem[pend_i] = pend_d;
                pend_v = 0;
            end
        end
        dut_ack = DCE_ReadAck;
        chk("read_ack", 32'(DCE_ReadAck), 32'(racc));
        if (racc) lsq_v = 0;
        if (t == wdone_cyc && sbq.size() > 0) sbq.delete(0);
        if (rst && clear_sb) sbq.delete();
    endtask

    task automatic req(input logic [31:0] a, input logic [5:0] tg);
        lsq_v = 1;
        lsq_a = a;
        lsq_t = tg;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sbq.size() > 0 || lsq_v || exq.size() > 0); i++) step(0, 0);
        step(0, 0);
        chk("drain_timeout", 32'(exq.size() + sbq.size()), 32'h0);
    endtask

    initial forever begin
        @(negedge Clk);
        #2;
        if (mon_en) begin
            if (DCE_WriteDone === 1'b1) wd_cycles.push_back(cyc);
            if (DCE_ReadDone === 1'b1) begin
                last_rd_data = DCE_ReadData;
                last_rd_tag = DCE_ReadTag;
            end
            if (DCE_WriteDone === 1'b1 || DCE_ReadDone === 1'b1) begin
                chk("both_done", 32'(DCE_WriteDone & DCE_ReadDone), 32'h0);
                if (exq.size() == 0 || exq[0].cyc != cyc)
                    chk("unexpected_done", 32'(DCE_WriteDone | DCE_ReadDone), 32'h0);
                else begin
                    chk("done_kind", 32'(DCE_ReadDone), 32'(exq[0].rd));
                    if (exq[0].rd) begin
                        chk("rd_data", DCE_ReadData, exq[0].data);
                        chk("rd_tag", 32'(DCE_ReadTag), 32'(exq[0].tag));
                    end
                    exq.delete(0);
                end
            end
            while (exq.size() > 0 && exq[0].cyc <= cyc) begin
                chk(exq[0].rd ? "missing_read_done" : "missing_write_done",
                    32'(exq[0].rd ? DCE_ReadDone : DCE_WriteDone), 32'h1);
                exq.delete(0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d4 [4];
        int n0, c, nw;
        bit r;
        // Reset with both requesters active; the store must win once released.
        sbq.push_back('{32'h0000_0010, 32'hDEAD_BEEF});
        req(32'h0000_0010, 6'h2A);
        step(1, 0);
        step(1, 0);
        mon_en = 1;
        chk("rst_write_done", 32'(DCE_WriteDone), 32'h0);
        chk("rst_read_done", 32'(DCE_ReadDone), 32'h0);
        chk("rst_read_data", DCE_ReadData, 32'h0);
        chk("rst_read_tag", 32'(DCE_ReadTag), 32'h0);
        drain();
        chk("single_store_rd_data", last_rd_data, 32'hDEAD_BEEF);
        chk("single_store_rd_tag", 32'(last_rd_tag), 32'h2A);
        // Store buffer full of four entries.
        n0 = wd_cycles.size();
        for (int k = 0; k < 4; k++) begin
            d4[k] = $urandom();
            sbq.push_back('{32'(k * 4), d4[k]});
        end
        drain();
        chk("four_store_count", 32'(wd_cycles.size() - n0), 32'h4);
        if (wd_cycles.size() - n0 == 4)
            for (int k = 1; k < 4; k++)
                chk("store_spacing", 32'(wd_cycles[n0+k] - wd_cycles[n0+k-1]), 32'(WL + 1));
        for (int k = 0; k < 4; k++) begin
            req(32'(k * 4), 6'(k + 1));
            drain();
            chk("four_store_readback", last_rd_data, d4[k]);
        end
        // Contention: both arrive together.
        sbq.push_back('{32'h0000_0030, 32'hCAFE_0030});
        req(32'h0000_0030, 6'h15);
        drain();
        chk("contention_readback", last_rd_data, 32'hCAFE_0030);
        // Flush two cycles into a read, then a fresh read right after.
        req(32'h0000_0004, 6'h01);
        for (int i = 0; i < 20 && lsq_v; i++) step(0, 0);
        req(32'h0000_0008, 6'h02);
        step(0, 0);
        step(0, 1);
        step(0, 0);
        chk("flush_reack", 32'(dut_ack), 32'h1);
        drain();
        chk("flush_second_read", last_rd_data, d4[2]);
        // Flush during a write is ignored.
        n0 = wd_cycles.size();
        sbq.push_back('{32'h0000_0034, 32'h0BAD_F00D});
        for (int i = 0; i < WL + 2; i++) step(0, 1);
        drain();
        chk("flush_write_done", 32'(wd_cycles.size() - n0), 32'h1);
        // Reset in the middle of a write abandons it.
        sbq.push_back('{32'h0000_0020, 32'h1111_1111});
        drain();
        n0 = wd_cycles.size();
        sbq.push_back('{32'h0000_0020, 32'h2222_2222});
        for (int i = 0; i < 20 && !pend_v; i++) step(0, 0);
        step(0, 0);
        clear_sb = 1;
        step(1, 0);
        clear_sb = 0;
        drain();
        chk("rst_mid_write_no_done", 32'(wd_cycles.size() - n0), 32'h0);
        req(32'h0000_0020, 6'h3F);
        drain();
        chk("rst_mid_write_readback", last_rd_data, 32'h1111_1111);
        // Random traffic over 16 words with aliasing upper and byte-offset bits.
        for (int k = 0; k < 16; k++) begin
            a = $urandom();
            a[9:2] = 8'(k);
            sbq.push_back('{a, $urandom()});
        end
        drain();
        nw = 0;
        for (int i = 0; i < 500; i++) begin
            if (sbq.size() < 4 && $urandom_range(0, 2) == 0) begin
                a = $urandom();
                a[9:6] = 4'h0;
                sbq.push_back('{a, $urandom()});
                nw++;
            end
            if (!lsq_v && $urandom_range(0, 1) == 0) begin
                a = $urandom();
                a[9:6] = 4'h0;
                req(a, 6'($urandom()));
            end
            r = $urandom_range(0, 99) == 0;
            clear_sb = r;
            step(r, $urandom_range(0, 7) == 0);
        end
        clear_sb = 0;
        drain();
        c = exq.size();
        chk("final_queue_empty", 32'(c), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
